mode_switch_arbiter: RTL and testbench

Round-robin arbiter that shares one mode-configured resource among N requesters. Each requester asks for access in a specific operating mode of the 2-bit mode enum: A=2'd0, B=2'd1, C=2'd3. The encoding 2'd2 is illegal. The block owns the resource's mode register and sequences a fixed settle period whenever the granted requester needs a different mode. It then holds the grant until the requester signals completion.

---
 rtl/mode_switch_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mode_switch_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mode_switch_arbiter.sv
// Round-robin arbiter for one mode-configured resource with a settle period on mode change.
// Define MODE_SWITCH_ARBITER_STICKY_EN to prefer requesters that match the current mode.
module mode_switch_arbiter #(
    parameter int N            = 4,
    parameter int SETTLE       = 3,
    parameter int STICKY_LIMIT = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [N-1:0]   i_req,
    input  logic [2*N-1:0] i_mode,
    input  logic [N-1:0]   i_done,
    output logic [N-1:0]   o_gnt,
    output logic [1:0]     o_mode,
    output logic           o_switching,
    output logic           o_err
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [1:0] MODE_A   = 2'd0;
    localparam logic [1:0] MODE_ILL = 2'd2;

    if (N < 2 || N > 8 || SETTLE < 1 || STICKY_LIMIT < 1) begin : g_param_chk
        $error("mode_switch_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWITCH,
        S_GRANT
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     mode_q, mode_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic           err_q, err_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [PW-1:0]  win_q, win_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [N-1:0]   elig;
    logic           illegal;
    logic [PW:0]    pick;
    logic [PW-1:0]  pick_idx;
    logic [1:0]     pick_mode;

    // Lowest offset from ptr wins; loop runs high-to-low so the last hit is the winner.
    function automatic logic [PW:0] rr_pick(input logic [N-1:0] mask,
                                            input logic [PW-1:0] ptr);
        logic [PW:0] r;
        int          j;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (mask[j[PW-1:0]]) r = {1'b1, j[PW-1:0]};
        end
        return r;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [PW-1:0] idx);
        return {{(N-1){1'b0}}, 1'b1} << idx;
    endfunction

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] idx);
        return (int'(idx) == N - 1) ? '0 : idx + 1'b1;
    endfunction

`ifdef MODE_SWITCH_ARBITER_STICKY_EN
    localparam int SW = $clog2(STICKY_LIMIT + 1);
    logic [SW-1:0] sticky_q, sticky_d;
    logic [N-1:0]  same;
    logic          diff_pend;
    logic          sticky_hit;
`endif

    always_comb begin
        illegal = 1'b0;
        for (int k = 0; k < N; k++) begin
            elig[k] = i_req[k] && (i_mode[2*k +: 2] != MODE_ILL);
            if (i_req[k] && (i_mode[2*k +: 2] == MODE_ILL)) illegal = 1'b1;
        end
    end

`ifdef MODE_SWITCH_ARBITER_STICKY_EN
    always_comb begin
        for (int k = 0; k < N; k++) begin
            same[k] = elig[k] && (i_mode[2*k +: 2] == mode_q);
        end
        diff_pend  = |(elig & ~same);
        sticky_hit = (sticky_q >= SW'(STICKY_LIMIT));
        if (|same && !sticky_hit) pick = rr_pick(same, ptr_q);
        else                      pick = rr_pick(elig, ptr_q);
    end
`else
    always_comb pick = rr_pick(elig, ptr_q);
`endif

    assign pick_idx  = pick[PW-1:0];
    assign pick_mode = i_mode[2*int'(pick_idx) +: 2];

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        err_d   = illegal;
`ifdef MODE_SWITCH_ARBITER_STICKY_EN
        sticky_d = sticky_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (pick[PW]) begin
                    win_d = pick_idx;
                    if (pick_mode == mode_q) begin
                        state_d = S_GRANT;
                        gnt_d   = onehot(pick_idx);
                    end else begin
                        state_d = S_SWITCH;
                        mode_d  = pick_mode;
                        cnt_d   = CW'(SETTLE - 1);
                    end
`ifdef MODE_SWITCH_ARBITER_STICKY_EN
                    if (pick_mode != mode_q || sticky_hit) sticky_d = '0;
                    else if (diff_pend)                   sticky_d = sticky_q + 1'b1;
`endif
                end
            end
            S_SWITCH: begin
                if (cnt_q == '0) begin
                    state_d = S_GRANT;
                    gnt_d   = onehot(win_q);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_GRANT: begin
                if (i_done[win_q] || !i_req[win_q]) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    ptr_d   = ptr_next(win_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_A;
            gnt_q   <= '0;
            ptr_q   <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
`ifdef MODE_SWITCH_ARBITER_STICKY_EN
            sticky_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef MODE_SWITCH_ARBITER_STICKY_EN
            sticky_q <= sticky_d;
`endif
        end
    end

    assign o_gnt       = gnt_q;
    assign o_mode      = mode_q;
    assign o_switching = (state_q == S_SWITCH);
    assign o_err       = err_q;

endmodule

// File: tb/tb_mode_switch_arbiter.sv
// Scoreboard bench for mode_switch_arbiter: expected grants are queued
// with mode, idle gap and switch cycles, then matched as grants appear.
module tb_mode_switch_arbiter;

    localparam int N      = 4;
    localparam int SETTLE = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [2*N-1:0] mode;
    logic [N-1:0]   done;
    logic [N-1:0]   gnt;
    logic [1:0]     omode;
    logic           sw;
    logic           err;

    typedef struct {
        logic [N-1:0] gnt;
        logic [1:0]   mode;
        int           gap;
        int           sw;
    } exp_t;

    exp_t exp_q[$];
    int   rem[N];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mode_switch_arbiter #(.N(N), .SETTLE(SETTLE), .STICKY_LIMIT(4)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_req(req),
        .i_mode(mode),
        .i_done(done),
        .o_gnt(gnt),
        .o_mode(omode),
        .o_switching(sw),
        .o_err(err)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [N-1:0] g, input logic [1:0] m,
                        input int gap, input int swc);
        exp_t e;
        e.gnt = g; e.mode = m; e.gap = gap; e.sw = swc;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; done = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive requests from rem[], answer each grant with done after hold cycles.
    task automatic run(input int hold, input logic err_exp);
        int   gap = 0, swc = 0, held = 0, cyc = 0, k = 0;
        logic active = 1'b0;
        exp_t e;
        for (int i = 0; i < N; i++) req[i] = (rem[i] > 0);
        forever begin
            @(negedge clk);
            done = '0;
            cyc++;
            if (gnt == '0) begin
                gap++;
                if (sw) swc++;
                active = 1'b0;
            end else begin
                if (!active) begin
                    active = 1'b1;
                    held   = 0;
                    check("onehot", 32'($onehot(gnt)), 32'd1);
                    if (exp_q.size() == 0) begin
                        check("extra_gnt", 32'(gnt), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("gnt", 32'(gnt), 32'(e.gnt));
                        check("mode", 32'(omode), 32'(e.mode));
                        check("gap", gap, e.gap);
                        check("sw_cycles", swc, e.sw);
                        if (err_exp) check("err_hold", 32'(err), 32'd1);
                    end
                    gap = 0;
                    swc = 0;
                end
                held++;
                if (held == hold) begin
                    for (int i = 0; i < N; i++) if (gnt[i]) k = i;
                    done[k] = 1'b1;
                    rem[k]--;
                    if (rem[k] <= 0) req[k] = 1'b0;
                end
            end
            if (exp_q.size() == 0 && gnt == '0) break;
            if (cyc > 300) begin
                check("timeout", 32'(exp_q.size()), 32'd0);
                exp_q.delete();
                break;
            end
        end
        req  = '0;
        done = '0;
    endtask

    initial begin
        rst = 1'b1; req = '0; mode = '0; done = '0;
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_mode", 32'(omode), 32'd0);
        check("rst_sw", 32'(sw), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;

        // Matching-mode grant, then pointer sits at 1
        rem = '{1, 0, 0, 0}; mode = 8'h00;
        push(4'b0001, 2'd0, 0, 0);
        run(1, 1'b0);
        rem = '{1, 1, 0, 0};
        push(4'b0010, 2'd0, 0, 0);
        push(4'b0001, 2'd0, 1, 0);
        run(1, 1'b0);

        // Mode change to C with settle
        do_reset();
        rem = '{1, 0, 0, 0}; mode = 8'h03;
        push(4'b0001, 2'd3, SETTLE, SETTLE);
        run(1, 1'b0);

        // Four requesters, same mode, round robin wraps
        do_reset();
        rem = '{2, 1, 1, 1}; mode = 8'h00;
        push(4'b0001, 2'd0, 0, 0);
        push(4'b0010, 2'd0, 1, 0);
        push(4'b0100, 2'd0, 1, 0);
        push(4'b1000, 2'd0, 1, 0);
        push(4'b0001, 2'd0, 1, 0);
        run(2, 1'b0);

        // Illegal request never granted, error flag follows it
        do_reset();
        mode = 8'b00_01_10_00;
        req  = 4'b0010;
        @(negedge clk);
        check("err_set", 32'(err), 32'd1);
        check("err_nognt", 32'(gnt), 32'd0);
        repeat (3) @(negedge clk);
        check("err_idle_gnt", 32'(gnt), 32'd0);
        check("err_idle_sw", 32'(sw), 32'd0);
        rem = '{0, 1, 1, 0};
        push(4'b0100, 2'd1, SETTLE, SETTLE);
        run(1, 1'b1);
        @(negedge clk);
        check("err_clr", 32'(err), 32'd0);

        // Reset while switching
        do_reset();
        mode = 8'h01; req = 4'b0001;
        @(negedge clk);
        check("pre_sw", 32'(sw), 32'd1);
        check("pre_sw_mode", 32'(omode), 32'd1);
        rst = 1'b1; req = '0;
        @(negedge clk);
        check("rsw_gnt", 32'(gnt), 32'd0);
        check("rsw_mode", 32'(omode), 32'd0);
        check("rsw_sw", 32'(sw), 32'd0);
        rst = 1'b0;

        // Reset while granted drops the grant and the pointer
        rem = '{1, 0, 0, 0}; mode = 8'h00;
        push(4'b0001, 2'd0, 0, 0);
        run(1, 1'b0);
        req = 4'b0100;
        @(negedge clk);
        check("pre_gnt", 32'(gnt), 32'(4'b0100));
        rst = 1'b1; req = '0;
        @(negedge clk);
        check("rg_gnt", 32'(gnt), 32'd0);
        check("rg_mode", 32'(omode), 32'd0);
        check("rg_sw", 32'(sw), 32'd0);
        rst = 1'b0;
        rem = '{1, 1, 0, 0};
        push(4'b0001, 2'd0, 0, 0);
        push(4'b0010, 2'd0, 1, 0);
        run(1, 1'b0);

        // Mixed modes: 0 and 2 in A, 1 in B
        do_reset();
        mode = 8'b00_00_01_00;
`ifdef MODE_SWITCH_ARBITER_STICKY_EN
        rem = '{2, 1, 2, 0};
        push(4'b0001, 2'd0, 0, 0);
        push(4'b0100, 2'd0, 1, 0);
        push(4'b0001, 2'd0, 1, 0);
        push(4'b0100, 2'd0, 1, 0);
        push(4'b0010, 2'd1, SETTLE + 1, SETTLE);
`else
        rem = '{1, 1, 1, 0};
        push(4'b0001, 2'd0, 0, 0);
        push(4'b0010, 2'd1, SETTLE + 1, SETTLE);
        push(4'b0100, 2'd0, SETTLE + 1, SETTLE);
`endif
        run(1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
